// File: rtl/bus_sram_ctrl.sv
// Bus slave that turns level-held bus_read/bus_write requests into timed strobe
// sequences for a 32-bit asynchronous SRAM. Define SRAM_CTRL_POSTED_WRITE_EN to ack writes at once.
module bus_sram_ctrl #(
  parameter int ADDR_WIDTH = 20,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           bus_address,
  input  logic [3:0]            bus_byteenable,
  input  logic                  bus_read,
  input  logic                  bus_write,
  input  logic [31:0]           bus_wrdata,
  output logic [31:0]           bus_rddata,
  output logic                  bus_stall,
  output logic                  bus_ack,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_o,
  output logic                  sram_data_oe,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_was_write;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [31:0]           r_data_o;
  logic [31:0]           r_rddata;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic [3:0]            r_be_n;
  logic                  r_data_oe;

  logic w_req;
  logic w_last;
  logic w_ack;
  logic w_unused_addr_bits;

  assign w_req  = bus_read | bus_write;
  assign w_last = (r_cnt == CW'(1));
  assign w_unused_addr_bits = ^{bus_address[31:ADDR_WIDTH+2], bus_address[1:0]};

`ifdef SRAM_CTRL_POSTED_WRITE_EN
  // A write is taken and acked straight from IDLE; the DONE that follows it stays silent.
  assign w_ack = !rst && (((r_state == S_DONE) && !r_was_write) ||
                          ((r_state == S_IDLE) && bus_write));
`else
  assign w_ack = !rst && (r_state == S_DONE);
`endif

  assign bus_ack   = w_ack;
  assign bus_stall = w_req && !w_ack;

  always_comb begin
    // NOTE: default first, so every path through the case assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus_write)     w_next = S_WRITE;
        else if (bus_read) w_next = S_READ;
      end
      S_READ:  if (w_last) w_next = S_DONE;
      S_WRITE: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_was_write <= 1'b0;
      r_sram_addr <= '0;
      r_data_o    <= '0;
      r_rddata    <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= 4'hF;
      r_data_oe   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; strobes are registered from w_next so
      // they change on the same edge as the state and never glitch toward the SRAM.
      r_state   <= w_next;
      r_ce_n    <= !((w_next == S_READ) || (w_next == S_WRITE));
      r_oe_n    <= (w_next != S_READ);
      r_we_n    <= (w_next != S_WRITE);
      r_data_oe <= (w_next == S_WRITE) || ((w_next == S_DONE) && r_was_write);

      if ((r_state == S_IDLE) && w_req) begin
        r_sram_addr <= bus_address[ADDR_WIDTH+1:2];
        r_data_o    <= bus_wrdata;
        r_be_n      <= bus_write ? ~bus_byteenable : 4'h0;
        r_was_write <= bus_write;
        r_cnt       <= bus_write ? WR_LOAD : RD_LOAD;
      end else if ((r_state == S_READ) || (r_state == S_WRITE)) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last) r_be_n <= 4'hF;
      end

      // Data is sampled on the edge that closes the OE window.
      if ((r_state == S_READ) && w_last) r_rddata <= sram_data_i;
    end
  end

  assign bus_rddata   = r_rddata;
  assign sram_addr    = r_sram_addr;
  assign sram_data_o  = r_data_o;
  assign sram_data_oe = r_data_oe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;

endmodule

// File: tb/tb_bus_sram_ctrl.sv
// Directed bench for bus_sram_ctrl: DUT 0 uses 1-cycle waits, DUT 1 uses 3-cycle waits,
// each behind a small byte-lane SRAM model. Posted-write expectations follow SRAM_CTRL_POSTED_WRITE_EN.
module tb_bus_sram_ctrl;

`ifdef SRAM_CTRL_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef struct {
    int          lat;
    int          stall_cyc;
    logic [31:0] rdat;
    logic        doe_ack;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] b_addr  [2];
  logic [3:0]  b_be    [2];
  logic        b_rd    [2];
  logic        b_wr    [2];
  logic [31:0] b_wdata [2];
  logic [31:0] rddata  [2];
  logic        stall   [2];
  logic        ack     [2];
  logic [19:0] s_addr  [2];
  logic [31:0] s_do    [2];
  logic        data_oe [2];
  logic [31:0] s_di    [2];
  logic        ce_n    [2];
  logic        oe_n    [2];
  logic        we_n    [2];
  logic [3:0]  be_n    [2];

  // Free-running strobe monitor: counts strobe cycles and keeps the last strobe snapshot.
  int          we_total [2];
  int          oe_total [2];
  logic [19:0] last_addr [2];
  logic [3:0]  last_be_n [2];
  logic        last_doe  [2];
  logic [31:0] last_do   [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t r;
  res_t r2;
  int   we0, oe0, acks;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [0:255];

    always @(posedge clk)
      if (!ce_n[g] && !we_n[g] && data_oe[g])
        for (int b = 0; b < 4; b++)
          if (!be_n[g][b]) mem[s_addr[g][7:0]][8*b +: 8] <= s_do[g][8*b +: 8];

    assign s_di[g] = (!ce_n[g] && !oe_n[g]) ? mem[s_addr[g][7:0]] : 32'hBAD0_BAD0;

    bus_sram_ctrl #(
      .ADDR_WIDTH(20),
      .RD_WAIT((g == 0) ? 1 : 3),
      .WR_WAIT((g == 0) ? 1 : 3)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .bus_address   (b_addr[g]),
      .bus_byteenable(b_be[g]),
      .bus_read      (b_rd[g]),
      .bus_write     (b_wr[g]),
      .bus_wrdata    (b_wdata[g]),
      .bus_rddata    (rddata[g]),
      .bus_stall     (stall[g]),
      .bus_ack       (ack[g]),
      .sram_addr     (s_addr[g]),
      .sram_data_o   (s_do[g]),
      .sram_data_oe  (data_oe[g]),
      .sram_data_i   (s_di[g]),
      .sram_ce_n     (ce_n[g]),
      .sram_oe_n     (oe_n[g]),
      .sram_we_n     (we_n[g]),
      .sram_be_n     (be_n[g])
    );
  end

  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (!ce_n[d] && (!we_n[d] || !oe_n[d])) begin
        if (!we_n[d]) we_total[d] <= we_total[d] + 1;
        if (!oe_n[d]) oe_total[d] <= oe_total[d] + 1;
        last_addr[d] <= s_addr[d];
        last_be_n[d] <= be_n[d];
        last_doe[d]  <= data_oe[d];
        last_do[d]   <= s_do[d];
      end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the request until ack, drops it at posedge+1 after the ack cycle.
  task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, output res_t o);
    o.lat = 0; o.stall_cyc = 0; o.rdat = '0; o.doe_ack = 1'b0;
    b_rd[d] = rd; b_wr[d] = wr; b_addr[d] = addr; b_wdata[d] = data; b_be[d] = be;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (stall[d]) o.stall_cyc++;
      if (ack[d]) begin
        o.lat = c; o.rdat = rddata[d]; o.doe_ack = data_oe[d];
        break;
      end
    end
    @(posedge clk); #1;
    b_rd[d] = 1'b0; b_wr[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      b_addr[d] = '0; b_be[d] = '0; b_rd[d] = 1'b0; b_wr[d] = 1'b0; b_wdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ce_n",    32'(ce_n[0]),    32'h1);
    check("rst_oe_n",    32'(oe_n[0]),    32'h1);
    check("rst_we_n",    32'(we_n[0]),    32'h1);
    check("rst_be_n",    32'(be_n[0]),    32'hF);
    check("rst_data_oe", 32'(data_oe[0]), 32'h0);
    check("rst_ack",     32'(ack[0]),     32'h0);
    check("rst_stall",   32'(stall[0]),   32'h0);
    check("rst_rddata",  rddata[0],       32'h0);
    check("rst_addr",    32'(s_addr[0]),  32'h0);
    check("rst_ce_n_d1", 32'(ce_n[1]),    32'h1);
    idle(1);

    // Full-word write
    we0 = we_total[0]; oe0 = oe_total[0];
    access(0, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r);
    idle(3);
    check("wr_latency",  32'(r.lat),       POSTED ? 32'd1 : 32'd3);
    check("wr_stall",    32'(r.stall_cyc), POSTED ? 32'd0 : 32'd2);
    check("wr_doe_ack",  32'(r.doe_ack),   POSTED ? 32'd0 : 32'd1);
    check("wr_we_cyc",   32'(we_total[0] - we0), 32'd1);
    check("wr_oe_cyc",   32'(oe_total[0] - oe0), 32'd0);
    check("wr_addr",     32'(last_addr[0]), 32'h0_0004);
    check("wr_be_n",     32'(last_be_n[0]), 32'h0);
    check("wr_data_oe",  32'(last_doe[0]),  32'h1);
    check("wr_data_o",   last_do[0],        32'hDEAD_BEEF);

    // Read back
    we0 = we_total[0]; oe0 = oe_total[0];
    access(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, r);
    check("rd_latency",  32'(r.lat),       32'd3);
    check("rd_stall",    32'(r.stall_cyc), 32'd2);
    check("rd_data",     r.rdat,           32'hDEAD_BEEF);
    check("rd_oe_cyc",   32'(oe_total[0] - oe0), 32'd1);
    check("rd_we_cyc",   32'(we_total[0] - we0), 32'd0);
    check("rd_be_n",     32'(last_be_n[0]), 32'h0);
    check("rd_data_oe",  32'(last_doe[0]),  32'h0);
    idle(2);
    @(negedge clk);
    check("rd_hold",     rddata[0],        32'hDEAD_BEEF);
    idle(1);

    // Byte-lane write over an existing word
    access(0, 1'b0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, r);
    idle(3);
    access(0, 1'b0, 1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, r);
    idle(3);
    check("bw_be_n",     32'(last_be_n[0]), 32'b1101);
    check("bw_addr",     32'(last_addr[0]), 32'h0_0008);
    access(0, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, r);
    check("bw_readback", r.rdat,           32'h1122_AA44);
    idle(1);

    // Read and write together: the write wins, no OE pulse
    we0 = we_total[0]; oe0 = oe_total[0];
    access(0, 1'b1, 1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, r);
    idle(3);
    check("rw_latency",  32'(r.lat),       POSTED ? 32'd1 : 32'd3);
    check("rw_oe_cyc",   32'(oe_total[0] - oe0), 32'd0);
    check("rw_we_cyc",   32'(we_total[0] - we0), 32'd1);
    check("rw_rd_hold",  rddata[0],        32'h1122_AA44);
    access(0, 1'b1, 1'b0, 32'h8000_0030, 32'h0, 4'h0, r);
    check("rw_readback", r.rdat,           32'hCAFE_F00D);
    idle(1);

    // Back-to-back write then read on the 3-cycle-wait instance
    access(1, 1'b0, 1'b1, 32'h8000_0040, 32'h5A5A_A5A5, 4'hF, r);
    access(1, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, r2);
    check("b2b_wr_lat",  32'(r.lat),       POSTED ? 32'd1 : 32'd5);
    check("b2b_rd_lat",  32'(r2.lat),      POSTED ? 32'd9 : 32'd5);
    check("b2b_rd_data", r2.rdat,          32'h5A5A_A5A5);
    idle(2);

    // Reset in the middle of a write wait
    b_wr[1] = 1'b1; b_addr[1] = 32'h8000_0050; b_wdata[1] = 32'h1234_5678; b_be[1] = 4'hF;
    idle(1);
    @(negedge clk);
    check("mid_we_n_act",  32'(we_n[1]),    32'h0);
    check("mid_doe_act",   32'(data_oe[1]), 32'h1);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0; b_wr[1] = 1'b0;
    @(negedge clk);
    check("mid_we_n_rst",  32'(we_n[1]),    32'h1);
    check("mid_ce_n_rst",  32'(ce_n[1]),    32'h1);
    check("mid_doe_rst",   32'(data_oe[1]), 32'h0);
    check("mid_rddata_rst", rddata[1],      32'h0);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (ack[1]) acks++;
      @(negedge clk);
    end
    check("mid_no_ack",    32'(acks),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
